// File: rtl/memory_pairs_shuffler_if.sv
// memory_pairs_shuffler_if: control inputs and registered deck/status
// outputs of the pairs shuffler.
interface memory_pairs_shuffler_if #(
   parameter int NUM_PAIRS = 3,
   parameter int VAL_W     = 4
);
   localparam int N = 2 * NUM_PAIRS;

   logic               enable;
   logic               restart;
   logic [N*VAL_W-1:0] cards;
   logic               busy;
   logic               endState;

   modport master (
      output enable, restart,
      input  cards, busy, endState
   );

   modport slave (
      input  enable, restart,
      output cards, busy, endState
   );
endinterface

// File: rtl/memory_pairs_shuffler.sv
// memory_pairs_shuffler: Fisher-Yates shuffle of a sorted pairs deck,
// drawing swap candidates from a free-running 16-bit Galois LFSR.
module memory_pairs_shuffler #(
   parameter int          NUM_PAIRS = 3,
   parameter int          VAL_W     = 4,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic                    clk,
   input logic                    rst,
   memory_pairs_shuffler_if.slave bus
);
   localparam int          N     = 2 * NUM_PAIRS;
   localparam int          IDX_W = $clog2(N);
   localparam logic [15:0] TAPS  = 16'hB400;

   typedef enum logic [1:0] {IDLE, SHUFFLE, DONE} state_t;
   typedef logic [N-1:0][VAL_W-1:0] deck_t;

   function automatic deck_t sorted_deck();
      deck_t d;
      for (int s = 0; s < N; s++) begin
         d[s] = VAL_W'((s >> 1) + 1);
      end
      return d;
   endfunction

   localparam deck_t SORTED = sorted_deck();

   state_t           state_q, state_d;
   deck_t            cards_q, cards_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] r;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             busy_q, busy_d;
   logic             end_q, end_d;

   always_comb begin
      state_d = state_q;
      cards_d = cards_q;
      idx_d   = idx_q;
      r       = lfsr_q[IDX_W-1:0];
      // LFSR runs regardless of enable so user timing adds entropy
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0);
      if (bus.restart) begin
         cards_d = SORTED;
         idx_d   = IDX_W'(N - 1);
         state_d = SHUFFLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  idx_d   = IDX_W'(N - 1);
                  state_d = SHUFFLE;
               end
            end
            SHUFFLE: begin
               if (bus.enable && (r <= idx_q)) begin
                  cards_d[idx_q] = cards_q[r];
                  cards_d[r]     = cards_q[idx_q];
                  if (idx_q == IDX_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     idx_d = idx_q - IDX_W'(1);
                  end
               end
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == SHUFFLE);
      end_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cards_q <= SORTED;
         idx_q   <= IDX_W'(N - 1);
         lfsr_q  <= SEED;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cards_q <= cards_d;
         idx_q   <= idx_d;
         lfsr_q  <= lfsr_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign bus.cards    = cards_q;
   assign bus.busy     = busy_q;
   assign bus.endState = end_q;
endmodule

// File: tb/tb_memory_pairs_shuffler.sv
// tb_memory_pairs_shuffler: directed hand vectors plus per-cycle
// reference model for 3 pairs, randomized runs for 8 pairs.
module tb_memory_pairs_shuffler;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   int checks = 0;
   int errors = 0;

   memory_pairs_shuffler_if #(.NUM_PAIRS(3), .VAL_W(4)) bus_a ();
   memory_pairs_shuffler_if #(.NUM_PAIRS(8), .VAL_W(4)) bus_b ();

   memory_pairs_shuffler #(.NUM_PAIRS(3), .VAL_W(4)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   memory_pairs_shuffler #(.NUM_PAIRS(8), .VAL_W(4)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   // reference model for the 3-pair instance
   int          m_deck [6];
   int          m_st;
   int          m_i;
   logic [15:0] m_lfsr;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pairs_ok(input logic [63:0] c, input int np);
      int cnt [16];
      int v;
      for (int k = 0; k < 16; k++) cnt[k] = 0;
      for (int s = 0; s < 2 * np; s++) begin
         v = int'(c[s*4 +: 4]);
         if (v < 1 || v > np) return 1'b0;
         cnt[v]++;
      end
      for (int k = 1; k <= np; k++) begin
         if (cnt[k] != 2) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [23:0] m_cards();
      logic [23:0] c;
      for (int s = 0; s < 6; s++) c[s*4 +: 4] = 4'(m_deck[s]);
      return c;
   endfunction

   task automatic model_step(input logic rn, input logic en,
                             input logic rs);
      int r;
      int t;
      if (!rn) begin
         m_st   = 0;
         m_i    = 5;
         m_lfsr = 16'hACE1;
         for (int s = 0; s < 6; s++) m_deck[s] = s / 2 + 1;
      end else begin
         r = int'(m_lfsr % 16'd8);
         if (rs) begin
            for (int s = 0; s < 6; s++) m_deck[s] = s / 2 + 1;
            m_i  = 5;
            m_st = 1;
         end else if (m_st == 0) begin
            if (en) begin
               m_i  = 5;
               m_st = 1;
            end
         end else if (m_st == 1 && en && r <= m_i) begin
            t            = m_deck[m_i];
            m_deck[m_i]  = m_deck[r];
            m_deck[r]    = t;
            if (m_i == 1) m_st = 2;
            else m_i--;
         end
         if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
         else m_lfsr = m_lfsr >> 1;
      end
   endtask

   task automatic tick_a();
      @(posedge clk);
      model_step(rst_a, bus_a.enable, bus_a.restart);
      #1;
      check("cards_model", 64'(bus_a.cards), 64'(m_cards()));
      check("busy_model", 64'(bus_a.busy), 64'(m_st == 1));
      check("end_model", 64'(bus_a.endState), 64'(m_st == 2));
      check("pairs_a", 64'(pairs_ok(64'(bus_a.cards), 3)), 64'd1);
   endtask

   // first shuffle after reset release with enable held high
   task automatic run_hand();
      rst_a         = 1'b1;
      bus_a.enable  = 1'b1;
      bus_a.restart = 1'b0;
      check("rel_cards", 64'(bus_a.cards), 64'h332211);
      check("rel_busy", 64'(bus_a.busy), 64'd0);
      tick_a();
      check("h_busy", 64'(bus_a.busy), 64'd1);
      check("h_cards0", 64'(bus_a.cards), 64'h332211);
      tick_a();
      check("h_cards1", 64'(bus_a.cards), 64'h132213);
      repeat (6) tick_a();
      check("h_cards7", 64'(bus_a.cards), 64'h132123);
      check("h_busy7", 64'(bus_a.busy), 64'd1);
      repeat (2) tick_a();
      check("h_end9", 64'(bus_a.endState), 64'd0);
      tick_a();
      check("h_end10", 64'(bus_a.endState), 64'd1);
      check("h_busy10", 64'(bus_a.busy), 64'd0);
      check("h_final", 64'(bus_a.cards), 64'h132123);
   endtask

   task automatic run_a_done(input int limit, input bit alt);
      int n;
      n = 0;
      while (m_st != 2 && n < limit) begin
         bus_a.enable = alt ? ((n / 8) % 2 == 0) : 1'b1;
         tick_a();
         n++;
      end
      bus_a.enable = 1'b1;
      check("done_a", 64'(bus_a.endState), 64'd1);
   endtask

   initial begin
      int p;
      int q;
      int n;
      rst_a         = 1'b0;
      rst_b         = 1'b0;
      bus_a.enable  = 1'b1;
      bus_a.restart = 1'b1;
      bus_b.enable  = 1'b0;
      bus_b.restart = 1'b0;

      repeat (4) tick_a();
      check("rst_cards", 64'(bus_a.cards), 64'h332211);
      check("rst_busy", 64'(bus_a.busy), 64'd0);
      check("rst_end", 64'(bus_a.endState), 64'd0);
      run_hand();

      bus_a.restart = 1'b1;
      tick_a();
      bus_a.restart = 1'b0;
      check("rs_done_cards", 64'(bus_a.cards), 64'h332211);
      check("rs_done_busy", 64'(bus_a.busy), 64'd1);
      check("rs_done_end", 64'(bus_a.endState), 64'd0);
      run_a_done(600, 1'b1);

      bus_a.restart = 1'b1;
      tick_a();
      bus_a.restart = 1'b0;
      repeat (3) tick_a();
      check("mid_busy", 64'(bus_a.busy), 64'd1);
      bus_a.restart = 1'b1;
      tick_a();
      bus_a.restart = 1'b0;
      check("rs_mid_cards", 64'(bus_a.cards), 64'h332211);
      check("rs_mid_busy", 64'(bus_a.busy), 64'd1);
      run_a_done(300, 1'b0);

      bus_a.restart = 1'b1;
      tick_a();
      bus_a.restart = 1'b0;
      repeat (3) tick_a();
      rst_a = 1'b0;
      tick_a();
      check("rst_mid_cards", 64'(bus_a.cards), 64'h332211);
      check("rst_mid_busy", 64'(bus_a.busy), 64'd0);
      check("rst_mid_end", 64'(bus_a.endState), 64'd0);
      run_hand();

      @(posedge clk);
      #1;
      rst_b = 1'b1;
      for (int run = 0; run < 200; run++) begin
         p = $urandom_range(20, 100);
         q = $urandom_range(0, 3);
         bus_b.restart = 1'b1;
         @(posedge clk);
         #1;
         bus_b.restart = 1'b0;
         check("b_start", 64'(bus_b.busy), 64'd1);
         n = 0;
         while (bus_b.endState !== 1'b1 && n < 3000) begin
            bus_b.enable  = ($urandom_range(0, 99) < p);
            bus_b.restart = ($urandom_range(0, 999) < q * 5);
            @(posedge clk);
            #1;
            check("b_pairs", 64'(pairs_ok(64'(bus_b.cards), 8)), 64'd1);
            check("b_excl", 64'(bus_b.busy & bus_b.endState), 64'd0);
            n++;
         end
         bus_b.restart = 1'b0;
         check("b_done", 64'(bus_b.endState), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
